// File: rtl/alu_issue_unit_pkg.sv
// rtl/alu_issue_unit_pkg.sv - opcode encodings and opcode classification helpers
// Exports: alu_op_e, OP_WIDTH, OP_ILLEGAL_MIN, op_illegal(), op_has_ov()
package alu_issue_unit_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MAX  = 3'd2,
    OP_MIN  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_ILL6 = 3'd6,
    OP_ILL7 = 3'd7
  } alu_op_e;

  // First opcode value that the ALU does not implement.
  localparam logic [OP_WIDTH-1:0] OP_ILLEGAL_MIN = 3'd6;

  function automatic logic op_illegal(input alu_op_e op);
    return (op >= OP_ILLEGAL_MIN);
  endfunction

  // Only the arithmetic ops define an overflow bit; for the rest the ALU
  // output is undefined and must be masked.
  function automatic logic op_has_ov(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// rtl/alu_issue_unit_if.sv - command, ALU and result signal bundle for alu_issue_unit
// Groups: in_* command handshake, alu_* ALU connection, res_* result handshake, ov_count
// slave: issue-unit side; master: producer/ALU/consumer side
interface alu_issue_unit_if #(parameter int WIDTH = 8);
  import alu_issue_unit_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic [OP_WIDTH-1:0] in_op;

  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic [OP_WIDTH-1:0] alu_op;
  logic [WIDTH-1:0]    alu_z;
  logic                alu_ov;

  logic                res_valid;
  logic                res_ready;
  logic [WIDTH-1:0]    res_z;
  logic                res_ov;
  logic                res_err;
  logic [7:0]          ov_count;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_z, alu_ov, res_ready,
    output in_ready, alu_a, alu_b, alu_op, res_valid, res_z, res_ov, res_err, ov_count
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_z, alu_ov, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, res_valid, res_z, res_ov, res_err, ov_count
  );

endinterface

// File: rtl/alu_issue_unit_cmd_fifo.sv
// rtl/alu_issue_unit_cmd_fifo.sv - command FIFO holding {a, b, op} entries
// Inputs: clk, rst, push + push_a/push_b/push_op, pop
// Outputs: head_a/head_b/head_op (zero when empty), count
module alu_cmd_fifo
  import alu_issue_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_a,
  input  logic [WIDTH-1:0]       push_b,
  input  logic [OP_WIDTH-1:0]    push_op,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_a,
  output logic [WIDTH-1:0]       head_b,
  output logic [OP_WIDTH-1:0]    head_op,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH + OP_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits, so wrap needs no compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_a, push_b, push_op};
  end

  assign {head_a, head_b, head_op} = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - buffered issue front-end for the combinational 8-bit ALU
// Ports: clk, rst (async, active-high), bus (alu_issue_unit_if.slave)
// Commands queue in alu_cmd_fifo; the head feeds the ALU and is captured into
// a single result slot presented on the res_* handshake.
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_unit_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]    head_a;
  logic [WIDTH-1:0]    head_b;
  logic [OP_WIDTH-1:0] head_op;
  logic [CW-1:0]       count;
  logic                push;
  logic                issue;
  alu_op_e             op;

  alu_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_a  (bus.in_a),
    .push_b  (bus.in_b),
    .push_op (bus.in_op),
    .pop     (issue),
    .head_a  (head_a),
    .head_b  (head_b),
    .head_op (head_op),
    .count   (count)
  );

  // in_ready depends on occupancy only, so a full FIFO never passes a
  // command straight through to the slot.
  assign bus.in_ready = (count != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign issue        = (count != '0) && (!bus.res_valid || bus.res_ready);

  // The FIFO returns zeros when empty, which keeps the ALU inputs quiet.
  assign bus.alu_a  = head_a;
  assign bus.alu_b  = head_b;
  assign bus.alu_op = head_op;
  assign op         = alu_op_e'(head_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_z     <= '0;
      bus.res_ov    <= 1'b0;
      bus.res_err   <= 1'b0;
    end else if (issue) begin
      bus.res_valid <= 1'b1;
      bus.res_z     <= op_illegal(op) ? '0 : bus.alu_z;
      // Select rather than AND so an undriven alu_ov cannot leak through.
      bus.res_ov    <= op_has_ov(op) ? bus.alu_ov : 1'b0;
      bus.res_err   <= op_illegal(op);
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ov_count <= 8'd0;
    end else if (bus.res_valid && bus.res_ready && bus.res_ov && (bus.ov_count != 8'hFF)) begin
      bus.ov_count <= bus.ov_count + 8'd1;
    end
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential front-end that wraps the combinational 8-bit ALU.
- Accepts operation commands (a, b, op) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle to the ALU, registers z/ov into a result slot, and presents the result over a second valid/ready handshake.
- Also flags illegal opcodes and keeps a saturating overflow count.

Parameters:
- WIDTH, 8, operand/result width; must equal ALU width.
- DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_op  output  3  to ALU OP.
- alu_z  input  WIDTH  from ALU Z.
- alu_ov  input  1  from ALU OV; may be z for op>=2.
- res_valid  output  1  result slot full.
- res_ready  input  1  consumer takes result.
- res_z  output  WIDTH  registered result.
- res_ov  output  1  registered overflow.
- res_err  output  1  illegal opcode (6 or 7).
- ov_count  output  8  saturating count of delivered results with res_ov=1.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-high: clk, rst.
  - rst clears FIFO pointers and count, res_valid, res_z, res_ov, res_err and ov_count to 0.
  - Reset mid-operation discards all queued and held commands.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MAX, 3 MIN, 4 SHL (A<<2), 5 SHR (B>>3).
  - 6 and 7 are illegal.
- Input handshake:
  - Push when in_valid && in_ready at the rising edge.
  - in_ready = (count != DEPTH); combinational from state only, never from in_valid.
  - Full: in_ready = 0; no push-through while full.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Issue:
  - The FIFO head drives alu_a/alu_b/alu_op combinationally while count > 0.
  - When the FIFO is empty, alu_a, alu_b and alu_op are driven to 0.
  - issue = (count > 0) && (!res_valid || res_ready).
  - On issue, the head is popped and the result slot loads:
    - res_z = alu_z for op 0-5, 0 for op 6/7;
    - res_ov = alu_ov for op 0/1 only, else 0 (a z on alu_ov must never propagate);
    - res_err = (op >= 6).
- Result handshake:
  - res_valid is set on issue.
  - res_valid is cleared when res_ready && !issue.
  - res_z/res_ov/res_err are stable while res_valid && !res_ready.
  - Back-to-back: with res_ready held high, one result per cycle.
- Latency:
  - A command accepted at edge N into an empty FIFO with the slot free gives res_valid in the cycle after edge N+1.
  - That is 2 edges; there is no bypass of an empty FIFO.
- ov_count:
  - Increments on each res_valid && res_ready with res_ov = 1.
  - Saturates at 255; never wraps.
- Ordering: results are delivered strictly in command order; no drops, no duplicates.

Decomposition:
- Shared include alu_defs.vh holds:
  - opcode constants OP_ADD..OP_SHR (0-5);
  - OP_WIDTH = 3;
  - the illegal-op threshold 6.
- One sub-module, alu_cmd_fifo, is natural:
  - parameterised WIDTH/DEPTH;
  - stores {a, b, op};
  - provides push/pop, head, count and full/empty.
- The issue logic and result register stay in alu_issue_unit.

Test Plan:
- Reset and idle: rst pulse while idle -> res_valid=0, ov_count=0, in_ready=1, alu_op=0.
- ADD overflow: a=0x70, b=0x20, op=0, res_ready=1 -> res_z=0x90, res_ov=1, res_valid 2 edges after accept, ov_count=1.
- Mixed stream of 4 back-to-back commands, res_ready=1:
  - SUB 0x05,0x03 -> 0x02, ov=0
  - MAX 0x12,0x34 -> 0x34
  - SHL a=0x21 -> 0x84
  - SHR b=0x40 -> 0x08
  - Required: one result per cycle, in order, res_ov=0 for the last three.
- Backpressure: hold res_ready=0 and push 5 commands -> the first DEPTH+1 (5) are accepted (4 in FIFO, 1 in the slot), then in_ready=0 and res_z stays frozen. Release -> all 5 results drain in order.
- Illegal op: op=6, a=0xFF, b=0xFF -> res_z=0x00, res_err=1, res_ov=0. The next legal command clears res_err.
- Saturation and async reset:
  - 260 ADD 0x7F+0x01 -> ov_count=255 (saturated).
  - Assert rst between clock edges with a full FIFO -> all outputs 0 immediately; the following commands restart cleanly.
